// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: the row/column matrix wires plus the decoded
// key event outputs. The scanner takes the master side; whatever reads the
// key events (and models the physical keypad) takes the slave side.
interface keypad_scan_if;
  logic [3:0] row_n;      // keypad rows, active low, asynchronous to clk
  logic [3:0] col_n;      // column drive, active low, one-hot-low
  logic [3:0] key_code;   // {col[1:0],row[1:0]} of last accepted key
  logic       key_valid;  // one-cycle pulse when key_code updates
  logic       key_down;   // accepted key still debounced-held

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner.
// Drives one column low per dwell period, samples the synchronised rows at the
// end of each dwell, assembles a 16-bit frame per full scan and debounces
// whole frames. A small FSM turns debounced frames into single-key press
// events: one code pulse per clean single-key press, nothing for chords,
// and no new event until every key has been released.
module keypad_scan #(
  parameter int SCAN_DIV = 1000,  // clk cycles per column dwell, >= 4
  parameter int DEBOUNCE = 4      // identical frames needed to accept, >= 2
) (
  input  logic           clk,
  input  logic           rst_n,
  keypad_scan_if.master  kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DOWN = 1'b1
  } state_t;

  // Internal reset: asserts together with rst_n, releases two clocks later
  logic [1:0] rst_pipe_reg;
  logic       arst_n;

  // Row synchroniser
  logic [3:0] row_meta_reg;
  logic [3:0] row_sync_reg;

  // Scan timing
  logic [DIV_W-1:0] dwell_reg;
  logic [1:0]       col_reg;
  logic             dwell_end;
  logic             frame_close;
  logic [3:0]       col_n_int;

  // Frame assembly and debounce
  logic [15:0]      frame_acc_reg;
  logic [15:0]      frame_new;
  logic [15:0]      prev_reg;
  logic [15:0]      deb_reg;
  logic [CNT_W-1:0] stable_reg;
  logic [CNT_W-1:0] stable_next;
  logic             accept_reg;
  logic             accept_next;

  // Key event FSM
  state_t     state_reg;
  state_t     state_next;
  logic [3:0] key_code_reg;
  logic [3:0] key_code_next;
  logic       key_valid_reg;
  logic       key_valid_next;
  logic       key_down_reg;
  logic       key_down_next;
  logic       deb_onehot;
  logic [3:0] deb_index;

  // Reset release is re-timed to clk so no flop sees a release near an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe_reg <= 2'b00;
    end else begin
      rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
    end
  end

  assign arst_n = rst_pipe_reg[1];

  // Two-flop synchroniser; nothing downstream looks at raw row_n
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= kp.row_n;
      row_sync_reg <= row_meta_reg;
    end
  end

  assign dwell_end   = (dwell_reg == DIV_W'(SCAN_DIV - 1));
  assign frame_close = dwell_end && (col_reg == 2'd3);

  // Dwell counter and column index; the column moves on the cycle after its sample
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dwell_reg <= '0;
      col_reg   <= 2'd0;
    end else if (dwell_end) begin
      dwell_reg <= '0;
      col_reg   <= col_reg + 2'd1;
    end else begin
      dwell_reg <= dwell_reg + DIV_W'(1);
    end
  end

  // One-hot-low column drive decoded from the column index
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign col_n_int[gi] = (col_reg != 2'(gi));
  end

  assign kp.col_n = col_n_int;

  // Frame as it stands including this cycle's sample (active-high keys)
  always_comb begin
    frame_new = frame_acc_reg;
    frame_new[{col_reg, 2'b00} +: 4] = ~row_sync_reg;
  end

  // Store each column's sample on the last dwell cycle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      frame_acc_reg <= '0;
    end else if (dwell_end) begin
      frame_acc_reg <= frame_new;
    end
  end

  // Stable-frame count: restart at 1 on change, saturate at DEBOUNCE;
  // accept only on the close that first reaches DEBOUNCE
  always_comb begin
    stable_next = stable_reg;
    accept_next = 1'b0;
    if (frame_close) begin
      if (frame_new == prev_reg) begin
        if (stable_reg != CNT_W'(DEBOUNCE)) begin
          stable_next = stable_reg + CNT_W'(1);
        end
        accept_next = (stable_reg == CNT_W'(DEBOUNCE - 1));
      end else begin
        stable_next = CNT_W'(1);
      end
    end
  end

  // Frame close: remember the frame, update the count, latch accepted frames
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prev_reg   <= '0;
      deb_reg    <= '0;
      stable_reg <= '0;
      accept_reg <= 1'b0;
    end else begin
      stable_reg <= stable_next;
      accept_reg <= accept_next;
      if (frame_close) begin
        prev_reg <= frame_new;
      end
      if (accept_next) begin
        deb_reg <= frame_new;
      end
    end
  end

  // Exactly-one-key test on the debounced frame
  assign deb_onehot = (deb_reg != 16'd0) && ((deb_reg & (deb_reg - 16'd1)) == 16'd0);

  // Bit position of the pressed key; only meaningful when deb_onehot is set
  always_comb begin
    deb_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (deb_reg[i]) begin
        deb_index = 4'(i);
      end
    end
  end

  // Key event FSM state and output registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg     <= IDLE;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_down_reg  <= key_down_next;
    end
  end

  // Next state: report a fresh single key from IDLE, wait in DOWN until all released
  always_comb begin
    state_next     = state_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_down_next  = key_down_reg;
    if (accept_reg) begin
      case (state_reg)
        IDLE: begin
          if (deb_onehot) begin
            key_code_next  = deb_index;
            key_valid_next = 1'b1;
            key_down_next  = 1'b1;
            state_next     = DOWN;
          end
        end
        DOWN: begin
          if (deb_reg == 16'd0) begin
            key_down_next = 1'b0;
            state_next    = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign kp.key_code  = key_code_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_down  = key_down_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames).
// A keypad model turns the set of pressed keys into row levels for whichever
// column is driven. Stimulus pushes expected key codes; the monitor pops one
// per key_valid pulse and flags pulses nobody expected.
module tb_keypad_scan;

  logic clk;
  logic rst_n;
  logic [15:0] keys;
  logic [3:0]  row_model;

  int total_cnt;
  int pass_cnt;
  int pulse_cnt;
  logic [3:0] exp_q[$];

  keypad_scan_if kif();

  keypad_scan #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key at (col c,row r) pulls row r low while column c is driven
  always_comb begin
    row_model = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (!kif.col_n[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4 + r]) row_model[r] = 1'b0;
        end
      end
    end
  end

  assign kif.row_n = row_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s act=%0h exp=%0h", name, act, exp);
    end else begin
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest expected code
  always @(negedge clk) begin
    if (rst_n && kif.key_valid) begin
      pulse_cnt++;
      if (exp_q.size() != 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("pulse_code", {28'd0, kif.key_code}, {28'd0, e});
        check("pulse_down", {31'd0, kif.key_down}, 32'd1);
      end else begin
        check("spurious_valid", {31'd0, kif.key_valid}, 32'd0);
      end
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_down(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (kif.key_down !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, kif.key_down}, {31'd0, val});
  endtask

  initial begin
    int p0;
    int n;
    logic [3:0] one;
    logic [3:0] exp_col;
    total_cnt = 0;
    pass_cnt  = 0;
    pulse_cnt = 0;
    keys  = 16'h0000;
    rst_n = 1'b0;
    one   = 4'b0001;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_col_n", {28'd0, kif.col_n}, 32'he);
    check("rst_code", {28'd0, kif.key_code}, 32'd0);
    check("rst_valid", {31'd0, kif.key_valid}, 32'd0);
    check("rst_down", {31'd0, kif.key_down}, 32'd0);
    rst_n = 1'b1;

    // Column stepping: 1101,1011,0111,1110, 4 cycles each
    n = 0;
    while (kif.col_n !== 4'b1101 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 16; k++) begin
      exp_col = ~(one << ((k / 4 + 1) % 4));
      check("col_step", {28'd0, kif.col_n}, {28'd0, exp_col});
      @(negedge clk);
    end

    // No keys: no pulses
    p0 = pulse_cnt;
    repeat (200) @(negedge clk);
    check("idle_no_valid", pulse_cnt - p0, 32'd0);

    // Single press col2/row1 -> code 1001
    keys = 16'h0200;
    exp_q.push_back(4'b1001);
    wait_drain(67, "press_latency");
    check("press_down", {31'd0, kif.key_down}, 32'd1);
    check("press_code_hold", {28'd0, kif.key_code}, 32'h9);

    // Release: key_down falls, no pulse
    p0 = pulse_cnt;
    keys = 16'h0000;
    wait_down(1'b0, 67, "release_down");
    check("release_no_valid", pulse_cnt - p0, 32'd0);
    check("release_code_hold", {28'd0, kif.key_code}, 32'h9);
    repeat (20) @(negedge clk);

    // Bounce col1/row1 once per frame for 4 frames, then stable
    p0 = pulse_cnt;
    for (int s = 0; s < 4; s++) begin
      keys = (s % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (16) @(negedge clk);
    end
    check("bounce_no_valid", pulse_cnt - p0, 32'd0);
    keys = 16'h0020;
    exp_q.push_back(4'd5);
    wait_drain(67, "bounce_accept");
    check("bounce_one_pulse", pulse_cnt - p0, 32'd1);
    keys = 16'h0000;
    wait_down(1'b0, 70, "bounce_release");
    repeat (20) @(negedge clk);

    // Chord col0/row0 + col3/row3: never reported
    p0 = pulse_cnt;
    keys = 16'h8001;
    repeat (100) @(negedge clk);
    check("chord_no_valid", pulse_cnt - p0, 32'd0);
    check("chord_down", {31'd0, kif.key_down}, 32'd0);
    keys = 16'h0000;
    repeat (70) @(negedge clk);

    // Rollover: press 0, add 15, drop 0, drop all, press 6
    p0 = pulse_cnt;
    keys = 16'h0001;
    exp_q.push_back(4'b0000);
    wait_drain(67, "roll_first");
    keys = 16'h8001;
    repeat (70) @(negedge clk);
    check("roll_two_down", {31'd0, kif.key_down}, 32'd1);
    keys = 16'h8000;
    repeat (70) @(negedge clk);
    check("roll_second_down", {31'd0, kif.key_down}, 32'd1);
    check("roll_code_hold", {28'd0, kif.key_code}, 32'd0);
    keys = 16'h0000;
    wait_down(1'b0, 70, "roll_all_up");
    keys = 16'h0040;
    exp_q.push_back(4'b0110);
    wait_drain(67, "roll_fresh");
    check("roll_two_pulses", pulse_cnt - p0, 32'd2);

    // Reset while key held: outputs clear immediately
    check("pre_rst_down", {31'd0, kif.key_down}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_col_n", {28'd0, kif.col_n}, 32'he);
    check("mid_rst_code", {28'd0, kif.key_code}, 32'd0);
    check("mid_rst_valid", {31'd0, kif.key_valid}, 32'd0);
    check("mid_rst_down", {31'd0, kif.key_down}, 32'd0);
    repeat (3) @(negedge clk);

    // Release reset with key still held: reported again after debounce
    rst_n = 1'b1;
    exp_q.push_back(4'b0110);
    wait_drain(80, "post_rst_press");

    keys = 16'h0000;
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
